ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction fetch initiator for the byte-addressable instruction memory. It drives word addresses starting at BASE_ADDR, samples the memory's combinational read data, and buffers {pc, instruction} pairs in a small FIFO. The decode stage drains the FIFO over a valid/ready handshake. The unit only reads, so the memory's read_write control is held at 0.

Parameters:
BASE_ADDR, 32'h01000000, reset PC and lowest legal fetch address
MEM_DEPTH, 32'h00001000, instruction memory size in bytes; legal range is BASE_ADDR .. BASE_ADDR+MEM_DEPTH-4
FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2)

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
fetch_enable  input  1  permits fetching when high
imem_address  output  32  word address presented to instruction memory (= fetch_pc)
imem_read_write  output  1  memory write enable; constant 0
imem_data  input  32  combinational read data for imem_address
redirect_valid  input  1  branch/jump redirect request, single-cycle pulse
redirect_pc  input  32  redirect target
inst_valid  output  1  FIFO head is valid
inst_ready  input  1  consumer accepts head this cycle
inst_pc  output  32  PC of head entry
inst_data  output  32  instruction word of head entry
fetch_fault  output  1  sticky fault flag: misaligned or out-of-range fetch PC
fault_pc  output  32  offending PC captured on fault

Behaviour:
- Reset (sync, active-high) sets:
  - fetch_pc = BASE_ADDR, state = IDLE, FIFO count = 0, read/write pointers = 0.
  - inst_valid = 0, fetch_fault = 0, fault_pc = 0.
  - inst_pc and inst_data read 0 while the FIFO is empty.
- Reset asserted mid-operation discards all FIFO contents and any pending redirect in that cycle.
- States:
  - IDLE: no pushes. Moves to RUN when fetch_enable = 1.
  - RUN: while fetch_enable = 1 and there is space, pushes one entry per cycle. Returns to IDLE when fetch_enable = 0; FIFO contents are retained and can still be drained.
  - FAULT: no pushes. Left only by reset or by a redirect to a legal PC, which clears fetch_fault and moves to RUN if fetch_enable = 1, else IDLE.
- Push condition, in RUN with no redirect this cycle: count < FIFO_DEPTH, or count == FIFO_DEPTH with a pop in the same cycle.
  - On push: write {fetch_pc, imem_data} at the write pointer, then fetch_pc <= fetch_pc + 4 (32-bit wrap).
- Pop: inst_valid && inst_ready. The head advances at the clock edge.
- Simultaneous push and pop: count is unchanged.
- Latency: an instruction pushed at edge N is visible on inst_* after edge N. First inst_valid is 1 cycle after the first RUN cycle.
- Throughput: 1 instruction/cycle in steady state with inst_ready = 1.
- FIFO outputs come directly from registered storage; there is no combinational path from imem_data to inst_*.
- Legality check on fetch_pc before each push:
  - Illegal if fetch_pc[1:0] != 0, or fetch_pc < BASE_ADDR, or fetch_pc > BASE_ADDR+MEM_DEPTH-4.
  - Illegal PC: no push; fetch_fault <= 1; fault_pc <= fetch_pc; state <= FAULT.
  - Entries already in the FIFO remain drainable.
- Redirect (redirect_valid = 1) has priority over push and pop in the same cycle:
  - FIFO flushed: count = 0, pointers = 0, so inst_valid = 0 next cycle.
  - Any pop offered that cycle is ignored; the consumer must not treat a handshake coincident with a redirect as accepted.
  - fetch_pc <= redirect_pc; no push that cycle.
  - Legality of the target is checked on the next push attempt.
- Redirect while in IDLE: updates fetch_pc and flushes; stays IDLE.
- Sequential fetch crossing the top of memory raises a fault at PC BASE_ADDR+MEM_DEPTH. It does not wrap to BASE_ADDR.
- imem_read_write is tied to 0 at all times, including during reset.

Test Plan:
- Reset then fetch_enable = 1, inst_ready = 1, memory words 0x00000013, 0x00100093, 0x00200113 -> inst_valid rises one cycle after entering RUN; inst_pc sequence 0x01000000, 0x01000004, 0x01000008 with matching inst_data, one per cycle.
- inst_ready = 0 for 8 cycles -> exactly 4 pushes, imem_address holds 0x01000010. Raising inst_ready gives 1/cycle output with no gap or duplicate, including a simultaneous push/pop while full.
- Redirect to 0x01000100 in the same cycle as a pop with 3 entries buffered -> next cycle inst_valid = 0. Next delivered inst_pc is 0x01000100; no stale PCs appear.
- Redirect to 0x01000102 -> fetch_fault = 1, fault_pc = 0x01000102, no further pushes. A later redirect to 0x01000200 clears the fault and fetching resumes from 0x01000200.
- Sequential fetch from 0x01000FF8 with MEM_DEPTH = 0x1000 -> entries for 0x01000FF8 and 0x01000FFC, then fault with fault_pc = 0x01001000.
- Assert reset for 1 cycle mid-stream with FIFO full -> next cycle inst_valid = 0, imem_address = 0x01000000, state IDLE until fetch_enable. imem_read_write stays 0 throughout all tests.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch initiator: walks word addresses from BASE_ADDR, captures the
// memory's combinational read data and buffers {pc, instruction} pairs for decode.
module ifetch_unit #(
  parameter logic [31:0] BASE_ADDR  = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_enable,
  output logic [31:0] imem_address,
  output logic        imem_read_write,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  output logic        fetch_fault,
  output logic [31:0] fault_pc,
  output logic [1:0]  fsm_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [31:0]   LAST_ADDR = BASE_ADDR + MEM_DEPTH - 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   buf_pc   [FIFO_DEPTH];
  logic [31:0]   buf_data [FIFO_DEPTH];

  logic pop;
  logic try_push;
  logic fetch_legal;
  logic do_push;

  function automatic logic pc_legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc >= BASE_ADDR) && (pc <= LAST_ADDR);
  endfunction

  // Handshake: an entry transfers on a clock edge where inst_valid && inst_ready
  // are both high, except that a coincident redirect cancels the transfer.
  assign pop         = inst_valid && inst_ready && !redirect_valid;
  assign try_push    = (state == ST_RUN) && fetch_enable && !redirect_valid &&
                       ((count < DEPTH_C) || pop);
  assign fetch_legal = pc_legal(fetch_pc);
  assign do_push     = try_push && fetch_legal;

  assign imem_address    = fetch_pc;
  assign imem_read_write = 1'b0;
  assign fsm_state       = state;

  assign inst_valid = (count != '0);
  assign inst_pc    = inst_valid ? buf_pc[rd_ptr]   : 32'd0;
  assign inst_data  = inst_valid ? buf_data[rd_ptr] : 32'd0;

  always_ff @(posedge clock) begin
    if (do_push) begin
      buf_pc[wr_ptr]   <= fetch_pc;
      buf_data[wr_ptr] <= imem_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      fetch_pc    <= BASE_ADDR;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fetch_fault <= 1'b0;
      fault_pc    <= 32'd0;
    end else begin
      if (redirect_valid) begin
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= redirect_pc;
      end else begin
        if (do_push) begin
          wr_ptr   <= wr_ptr + PW'(1);
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (do_push && !pop) begin
          count <= count + CW'(1);
        end else if (!do_push && pop) begin
          count <= count - CW'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          if (!redirect_valid && fetch_enable) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!fetch_enable) begin
            state <= ST_IDLE;
          end else if (try_push && !fetch_legal) begin
            state       <= ST_FAULT;
            fetch_fault <= 1'b1;
            fault_pc    <= fetch_pc;
          end
        end
        ST_FAULT: begin
          // An illegal redirect target leaves the unit parked in FAULT.
          if (redirect_valid && pc_legal(redirect_pc)) begin
            fetch_fault <= 1'b0;
            state       <= fetch_enable ? ST_RUN : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a model memory feeds imem_data and a queue of
// expected {pc, instruction} pairs is checked against every delivered entry.
module tb_ifetch_unit;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] LAST = 32'h0100_0FFC;
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_FAULT = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic [31:0] imem_address;
  logic        imem_read_write;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [1:0]  fsm_state;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ifetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .fetch_enable    (fetch_enable),
    .imem_address    (imem_address),
    .imem_read_write (imem_read_write),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_pc         (inst_pc),
    .inst_data       (inst_data),
    .fetch_fault     (fetch_fault),
    .fault_pc        (fault_pc),
    .fsm_state       (fsm_state)
  );

  always #5 clock = ~clock;

  // Model memory: addi xi, x0, i at word i; out-of-range reads return a marker.
  function automatic logic [31:0] word_at(input logic [31:0] addr);
    logic [31:0] idx;
    if (addr[1:0] != 2'b00 || addr < BASE || addr > LAST) return 32'hDEAD_BEEF;
    idx = (addr - BASE) >> 2;
    return (idx << 20) | ((idx & 32'd31) << 7) | 32'h13;
  endfunction

  assign imem_data = word_at(imem_address);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, word_at(pc)});
  endtask

  // Accept the head this cycle; it must already be valid.
  task automatic drain_one();
    logic [63:0] exp;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_underflow observed=empty expected=entry");
      $fatal(1, "scoreboard underflow");
    end
    exp = exp_q.pop_front();
    inst_ready = 1'b1;
    check("drain_valid", 64'(inst_valid), 64'd1);
    check("drain_pc", 64'(inst_pc), 64'(exp[63:32]));
    check("drain_data", 64'(inst_data), 64'(exp[31:0]));
    check("read_write", 64'(imem_read_write), 64'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; fetch_enable = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    tick(); tick();
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_fault", 64'(fetch_fault), 64'd0);
    check("rst_fault_pc", 64'(fault_pc), 64'd0);
    check("rst_inst_pc", 64'(inst_pc), 64'd0);
    check("rst_inst_data", 64'(inst_data), 64'd0);
    check("rst_addr", 64'(imem_address), 64'(BASE));
    check("rst_state", 64'(fsm_state), 64'(S_IDLE));
    check("rst_read_write", 64'(imem_read_write), 64'd0);

    // Basic streaming: valid one cycle after entering RUN, then one per cycle.
    reset = 1'b0; fetch_enable = 1'b1; inst_ready = 1'b1;
    tick();
    check("run_state", 64'(fsm_state), 64'(S_RUN));
    check("first_cycle_valid", 64'(inst_valid), 64'd0);
    tick();
    check("first_word", 64'(inst_data), 64'h0000_0013);
    expect_pc(BASE); expect_pc(BASE + 32'h4); expect_pc(BASE + 32'h8);
    check("second_word_model", 64'(word_at(BASE + 32'h4)), 64'h0010_0093);
    repeat (3) drain_one();

    // Backpressure: four pushes fill the buffer, then fetch stalls.
    reset = 1'b1; inst_ready = 1'b0;
    tick();
    check("midrst_valid", 64'(inst_valid), 64'd0);
    reset = 1'b0;
    repeat (8) tick();
    check("stall_addr", 64'(imem_address), 64'(BASE + 32'h10));
    check("stall_head", 64'(inst_pc), 64'(BASE));
    for (int i = 0; i < 6; i++) expect_pc(BASE + 32'(4 * i));
    repeat (6) drain_one();

    // Drop to three buffered entries, then redirect alongside an offered pop.
    fetch_enable = 1'b0;
    expect_pc(BASE + 32'h18);
    drain_one();
    check("idle_state", 64'(fsm_state), 64'(S_IDLE));
    fetch_enable = 1'b1; inst_ready = 1'b0;
    tick();
    check("three_buffered_head", 64'(inst_pc), 64'(BASE + 32'h1C));
    redirect_valid = 1'b1; redirect_pc = BASE + 32'h100; inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush_valid", 64'(inst_valid), 64'd0);
    check("redir_addr", 64'(imem_address), 64'(BASE + 32'h100));
    expect_pc(BASE + 32'h100); expect_pc(BASE + 32'h104);
    tick();
    repeat (2) drain_one();

    // Misaligned redirect target faults and halts fetch.
    redirect_valid = 1'b1; redirect_pc = BASE + 32'h102;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("mis_fault", 64'(fetch_fault), 64'd1);
    check("mis_fault_pc", 64'(fault_pc), 64'(BASE + 32'h102));
    check("mis_state", 64'(fsm_state), 64'(S_FAULT));
    repeat (3) tick();
    check("mis_no_push", 64'(inst_valid), 64'd0);
    check("mis_addr_hold", 64'(imem_address), 64'(BASE + 32'h102));
    redirect_valid = 1'b1; redirect_pc = BASE + 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("clear_fault", 64'(fetch_fault), 64'd0);
    check("clear_state", 64'(fsm_state), 64'(S_RUN));
    expect_pc(BASE + 32'h200); expect_pc(BASE + 32'h204);
    tick();
    repeat (2) drain_one();

    // Sequential fetch off the top of memory faults instead of wrapping.
    redirect_valid = 1'b1; redirect_pc = BASE + 32'hFF8;
    tick();
    redirect_valid = 1'b0;
    expect_pc(BASE + 32'hFF8); expect_pc(BASE + 32'hFFC);
    tick();
    repeat (2) drain_one();
    check("top_valid", 64'(inst_valid), 64'd0);
    check("top_fault", 64'(fetch_fault), 64'd1);
    check("top_fault_pc", 64'(fault_pc), 64'(BASE + 32'h1000));
    check("top_state", 64'(fsm_state), 64'(S_FAULT));

    // Fill the buffer, then reset for a single cycle.
    inst_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = BASE + 32'h40;
    tick();
    redirect_valid = 1'b0;
    repeat (5) tick();
    check("full_head", 64'(inst_pc), 64'(BASE + 32'h40));
    check("full_addr", 64'(imem_address), 64'(BASE + 32'h50));
    reset = 1'b1;
    tick();
    reset = 1'b0; fetch_enable = 1'b0;
    check("rst2_valid", 64'(inst_valid), 64'd0);
    check("rst2_addr", 64'(imem_address), 64'(BASE));
    check("rst2_state", 64'(fsm_state), 64'(S_IDLE));
    check("rst2_fault", 64'(fetch_fault), 64'd0);
    check("rst2_fault_pc", 64'(fault_pc), 64'd0);
    check("rst2_read_write", 64'(imem_read_write), 64'd0);
    repeat (2) tick();
    check("rst2_hold_idle", 64'(fsm_state), 64'(S_IDLE));
    check("rst2_hold_valid", 64'(inst_valid), 64'd0);
    fetch_enable = 1'b1; inst_ready = 1'b1;
    tick();
    check("rst2_run_valid", 64'(inst_valid), 64'd0);
    expect_pc(BASE); expect_pc(BASE + 32'h4);
    tick();
    repeat (2) drain_one();
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
